// File: rtl/hazard_unit_nway_if.sv
// Hazard-unit bus: decode/execute/memory/writeback control in, forwarding selects
// and per-lane stall/issue/flush controls out.
interface hazard_unit_nway_if #(
    parameter int unsigned LANES = 2
);
    localparam int unsigned FW = $clog2(2 * LANES + 1);

    logic [LANES-1:0]    valid_d;
    logic [5*LANES-1:0]  rs1_d;
    logic [5*LANES-1:0]  rs2_d;
    logic [5*LANES-1:0]  rd_d;
    logic [LANES-1:0]    regwrite_d;
    logic [LANES-1:0]    memop_d;
    logic [5*LANES-1:0]  rs1_e;
    logic [5*LANES-1:0]  rs2_e;
    logic [5*LANES-1:0]  rd_e;
    logic [LANES-1:0]    load_e;
    logic [LANES-1:0]    redirect_e;
    logic [5*LANES-1:0]  rd_m;
    logic [5*LANES-1:0]  rd_w;
    logic [LANES-1:0]    regwrite_m;
    logic [LANES-1:0]    regwrite_w;

    logic [FW*LANES-1:0] fwd_a_e;
    logic [FW*LANES-1:0] fwd_b_e;
    logic                stall_f;
    logic [LANES-1:0]    stall_d;
    logic [LANES-1:0]    issue_d;
    logic [LANES-1:0]    flush_d;
    logic [LANES-1:0]    flush_e;

    // Pipeline side: supplies stage state, consumes hazard controls.
    modport master (
        output valid_d, rs1_d, rs2_d, rd_d, regwrite_d, memop_d,
        output rs1_e, rs2_e, rd_e, load_e, redirect_e,
        output rd_m, rd_w, regwrite_m, regwrite_w,
        input  fwd_a_e, fwd_b_e, stall_f, stall_d, issue_d, flush_d, flush_e
    );

    // Hazard-unit side.
    modport slave (
        input  valid_d, rs1_d, rs2_d, rd_d, regwrite_d, memop_d,
        input  rs1_e, rs2_e, rd_e, load_e, redirect_e,
        input  rd_m, rd_w, regwrite_m, regwrite_w,
        output fwd_a_e, fwd_b_e, stall_f, stall_d, issue_d, flush_d, flush_e
    );
endinterface

// File: rtl/hazard_unit_nway.sv
// N-lane hazard/forwarding controller: operand forwarding, load-use stalls,
// in-bundle RAW / memory-port splitting and mispredict flush.
module hazard_unit_nway #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned MEM_PORTS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_unit_nway_if.slave hz
);
    localparam int unsigned FW = $clog2(2 * LANES + 1);
    localparam int unsigned CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int unsigned MW = $clog2(LANES + 1);

    typedef enum logic [0:0] {
        FULL  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [LANES-1:0] done_q, done_d;
    logic [CW-1:0]    ld_cnt_q, ld_cnt_d;

    logic [LANES-1:0] pend;
    logic [LANES-1:0] issue_mask;
    logic             lu_hit;
    logic             split_hit;
    logic             lane_hit;
    logic             redir_seen;
    logic [MW-1:0]    mem_cnt;

    function automatic logic [4:0] fld(input logic [5*LANES-1:0] v, input int i);
        return v[5*i +: 5];
    endfunction

    // M beats W regardless of lane; within a stage the later scan (higher lane) wins.
    function automatic logic [FW-1:0] fwd_pick(
        input logic [4:0]         rs,
        input logic [5*LANES-1:0] rd_m,
        input logic [LANES-1:0]   we_m,
        input logic [5*LANES-1:0] rd_w,
        input logic [LANES-1:0]   we_w
    );
        logic [FW-1:0] sel;
        sel = '0;
        if (rs != 5'd0) begin
            for (int k = 0; k < LANES; k++) begin
                if (we_w[k] && (rd_w[5*k +: 5] == rs)) sel = FW'(2 * k + 2);
            end
            for (int k = 0; k < LANES; k++) begin
                if (we_m[k] && (rd_m[5*k +: 5] == rs)) sel = FW'(2 * k + 1);
            end
        end
        return sel;
    endfunction

    always_comb begin : fwd_sel
        hz.fwd_a_e = '0;
        hz.fwd_b_e = '0;
        for (int l = 0; l < LANES; l++) begin
            hz.fwd_a_e[FW*l +: FW] = fwd_pick(fld(hz.rs1_e, l), hz.rd_m, hz.regwrite_m,
                                              hz.rd_w, hz.regwrite_w);
            hz.fwd_b_e[FW*l +: FW] = fwd_pick(fld(hz.rs2_e, l), hz.rd_m, hz.regwrite_m,
                                              hz.rd_w, hz.regwrite_w);
        end
    end

    // Lanes still waiting to leave the held bundle; invalid lanes never pend.
    always_comb begin : pend_mask
        pend = hz.valid_d & ((state_q == SPLIT) ? ~done_q : {LANES{1'b1}});
    end

    always_comb begin : load_use
        lu_hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (pend[i] && hz.load_e[j] && (fld(hz.rd_e, j) != 5'd0) &&
                    ((fld(hz.rs1_d, i) == fld(hz.rd_e, j)) ||
                     (fld(hz.rs2_d, i) == fld(hz.rd_e, j)))) begin
                    lu_hit = 1'b1;
                end
            end
        end
    end

    // Find the oldest pending lane that cannot issue alongside the lanes before it.
    always_comb begin : split_scan
        split_hit  = 1'b0;
        lane_hit   = 1'b0;
        issue_mask = pend;
        mem_cnt    = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_hit = 1'b0;
            for (int m = 0; m < LANES; m++) begin
                if ((m < k) && pend[m] && hz.regwrite_d[m] && (fld(hz.rd_d, m) != 5'd0) &&
                    ((fld(hz.rs1_d, k) == fld(hz.rd_d, m)) ||
                     (fld(hz.rs2_d, k) == fld(hz.rd_d, m)))) begin
                    lane_hit = 1'b1;
                end
            end
            if (pend[k] && hz.memop_d[k]) begin
                if (mem_cnt >= MW'(MEM_PORTS)) lane_hit = 1'b1;
                mem_cnt = mem_cnt + MW'(1);
            end
            if (pend[k] && lane_hit) split_hit = 1'b1;
            if (split_hit) issue_mask[k] = 1'b0;
        end
    end

    // Priority: redirect, then load-use stall, then bundle split, else release.
    always_comb begin : ctrl
        state_d    = state_q;
        done_d     = done_q;
        ld_cnt_d   = ld_cnt_q;
        redir_seen = 1'b0;
        hz.stall_f = 1'b0;
        hz.stall_d = '0;
        hz.issue_d = '0;
        hz.flush_d = '0;
        hz.flush_e = '0;

        if (|hz.redirect_e) begin
            hz.flush_d = '1;
            for (int j = 0; j < LANES; j++) begin
                if (redir_seen) hz.flush_e[j] = 1'b1;
                if (hz.redirect_e[j]) redir_seen = 1'b1;
            end
            state_d  = FULL;
            done_d   = '0;
            ld_cnt_d = '0;
        end else if ((ld_cnt_q != '0) || lu_hit) begin
            hz.stall_f = 1'b1;
            hz.stall_d = '1;
            hz.flush_e = '1;
            ld_cnt_d   = (ld_cnt_q != '0) ? (ld_cnt_q - CW'(1)) : CW'(LOAD_LAT - 1);
        end else if (split_hit) begin
            hz.issue_d = issue_mask;
            hz.stall_f = 1'b1;
            hz.stall_d = '1;
            hz.flush_e = ~issue_mask;
            done_d     = ((state_q == SPLIT) ? done_q : '0) | issue_mask;
            state_d    = SPLIT;
        end else begin
            hz.issue_d = pend;
            done_d     = '0;
            state_d    = FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q  <= FULL;
            done_q   <= '0;
            ld_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end
endmodule
